// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Optional ovf signal present when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned Width = 4
) ();
    logic             start;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             busy;
    logic             done;
    logic [Width-1:0] resta;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, resta, bout, ovf);
    modport slave  (input start, a, b, output busy, done, resta, bout, ovf);
`else
    modport master (output start, a, b, input busy, done, resta, bout);
    modport slave  (input start, a, b, output busy, done, resta, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: resta = a - b with borrow-out, one bit per clock, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int unsigned Width = 4
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned     CntW    = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [Width-1:0] a_q;
    logic [Width-1:0] b_q;
    logic [Width-1:0] sr_q;
    logic [CntW-1:0]  cnt_q;
    logic             borrow_q;
    logic [Width-1:0] resta_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q;
`endif

    logic             a_bit;
    logic             b_bit;
    logic             diff_bit;
    logic             borrow_d;
    logic [Width-1:0] sr_d;

    // Current bit's full-subtractor; the difference bit enters the shift reg at the MSB.
    always_comb begin
        a_bit    = a_q[cnt_q];
        b_bit    = b_q[cnt_q];
        diff_bit = a_bit ^ b_bit ^ borrow_q;
        borrow_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
        sr_d     = (sr_q >> 1) | (Width'(diff_bit) << (Width - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            resta_q  <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        sr_q     <= '0;
                        cnt_q    <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    sr_q     <= sr_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    // Results are published only once the final bit has been folded in.
                    if (cnt_q == LastCnt) begin
                        resta_q <= sr_d;
                        bout_q  <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf_q   <= (a_q[Width-1] != b_q[Width-1]) &&
                                   (sr_d[Width-1] != a_q[Width-1]);
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.resta = resta_q;
    assign bus.bout  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: Width=4 random run against a timing/arithmetic model,
// plus directed checks at Width=1 and Width=8.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.Width(4)) bus4 ();
    serial_subtractor_if #(.Width(1)) bus1 ();
    serial_subtractor_if #(.Width(8)) bus8 ();

    serial_subtractor #(.Width(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_subtractor #(.Width(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_subtractor #(.Width(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: acc is the edge number on which the last operation was accepted.
    int       cyc = 0;
    int       acc = -1000;
    logic [3:0] pend_res = '0, cur_res = '0;
    logic     pend_bout = 1'b0, cur_bout = 1'b0;
    logic     pend_ovf = 1'b0, cur_ovf = 1'b0;
    bit       chk_en = 1'b0;

    initial begin
        int ai, bi, sa, sb, sd;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                acc      = -1000;
                cur_res  = '0;
                cur_bout = 1'b0;
                cur_ovf  = 1'b0;
            end else begin
                cyc++;
                if (cyc == acc + W) begin
                    cur_res  = pend_res;
                    cur_bout = pend_bout;
                    cur_ovf  = pend_ovf;
                end
                if (bus4.start === 1'b1 && cyc >= acc + W + 2) begin
                    acc       = cyc;
                    ai        = int'(bus4.a);
                    bi        = int'(bus4.b);
                    pend_res  = 4'(ai - bi);
                    pend_bout = ai < bi;
                    sa        = (ai > 7) ? ai - 16 : ai;
                    sb        = (bi > 7) ? bi - 16 : bi;
                    sd        = sa - sb;
                    pend_ovf  = (sd > 7) || (sd < -8);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", 32'(bus4.busy), 32'(cyc >= acc && cyc < acc + W));
                check("done", 32'(bus4.done), 32'(cyc == acc + W));
                check("resta", 32'(bus4.resta), 32'(cur_res));
                check("bout", 32'(bus4.bout), 32'(cur_bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("ovf", 32'(bus4.ovf), 32'(cur_ovf));
`endif
            end
        end
    end

    task automatic run4(input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] exp_res, input logic exp_bout);
        int busy_cnt = 0;
        bit seen = 1'b0;
        @(negedge clk);
        #1;
        bus4.start = 1'b1;
        bus4.a     = av;
        bus4.b     = bv;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.a     = ~av;
        bus4.b     = ~bv;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (bus4.busy) busy_cnt++;
            if (bus4.done) seen = 1'b1;
        end
        check("w4_done_seen", 32'(seen), 32'd1);
        check("w4_busy_cycles", 32'(busy_cnt), 32'(W));
        check("w4_resta_lit", 32'(bus4.resta), 32'(exp_res));
        check("w4_bout_lit", 32'(bus4.bout), 32'(exp_bout));
        check("model_res_lit", 32'(cur_res), 32'(exp_res));
        check("model_bout_lit", 32'(cur_bout), 32'(exp_bout));
    endtask

    initial begin
        int  busy_cnt;
        bit  seen;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_resta", 32'(bus4.resta), 32'd0);
        #1 rst_n = 1'b1;

        run4(4'd9, 4'd3, 4'd6, 1'b0);
        run4(4'd3, 4'd9, 4'hA, 1'b1);
        run4(4'd7, 4'd7, 4'd0, 1'b0);
        run4(4'd0, 4'd15, 4'd1, 1'b1);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        run4(4'd8, 4'd1, 4'd7, 1'b0);
        check("ovf_8m1", 32'(bus4.ovf), 32'd1);
        run4(4'd5, 4'd3, 4'd2, 1'b0);
        check("ovf_5m3", 32'(bus4.ovf), 32'd0);
        run4(4'd7, 4'd15, 4'd8, 1'b1);
        check("ovf_7m15", 32'(bus4.ovf), 32'd1);
`endif

        // Random start density with operands changing every cycle.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            bus4.start = ($urandom % 3) != 0;
            bus4.a     = 4'($urandom);
            bus4.b     = 4'($urandom);
        end
        // Start held high: back-to-back operations.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            bus4.start = 1'b1;
            bus4.a     = 4'($urandom);
            bus4.b     = 4'($urandom);
        end
        @(negedge clk);
        #1 bus4.start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset mid-RUN after two bits.
        #1;
        bus4.start = 1'b1; bus4.a = 4'd12; bus4.b = 4'd3;
        @(posedge clk);
        #1 bus4.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus4.busy), 32'd0);
        check("midrst_done", 32'(bus4.done), 32'd0);
        check("midrst_resta", 32'(bus4.resta), 32'd0);
        check("midrst_bout", 32'(bus4.bout), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (bus4.done) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        run4(4'd5, 4'd2, 4'd3, 1'b0);

        // Width=1: done one edge after RUN entry.
        @(negedge clk);
        #1;
        bus1.start = 1'b1; bus1.a = 1'b0; bus1.b = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        check("w1_busy", 32'(bus1.busy), 32'd1);
        check("w1_done_early", 32'(bus1.done), 32'd0);
        @(posedge clk);
        #1;
        check("w1_done", 32'(bus1.done), 32'd1);
        check("w1_busy_off", 32'(bus1.busy), 32'd0);
        check("w1_resta", 32'(bus1.resta), 32'd1);
        check("w1_bout", 32'(bus1.bout), 32'd1);
        @(posedge clk);
        #1;
        check("w1_done_pulse", 32'(bus1.done), 32'd0);

        // Width=8.
        @(negedge clk);
        #1;
        bus8.start = 1'b1; bus8.a = 8'd200; bus8.b = 8'd55;
        @(posedge clk);
        #1;
        bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd255;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus8.busy) busy_cnt++;
            if (bus8.done) seen = 1'b1;
        end
        check("w8_done_seen", 32'(seen), 32'd1);
        check("w8_busy_cycles", 32'(busy_cnt), 32'd8);
        check("w8_resta", 32'(bus8.resta), 32'd145);
        check("w8_bout", 32'(bus8.bout), 32'd0);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
